// File: rtl/stream_differentiator_pkg.sv
// Shared types and default widths for the stream differentiator and its skid buffer.
package stream_differentiator_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  localparam int DEFAULT_IN_WIDTH  = 16;
  localparam int DEFAULT_OUT_WIDTH = 8;

endpackage

// File: rtl/stream_differentiator_skid_buffer.sv
// Two-entry skid buffer: main register M drives the outputs, skid register S absorbs
// the word that arrives while the output is stalled. Ready and valid are both registered.
module stream_differentiator_skid_buffer
  import stream_differentiator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_OUT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  buf_state_e       state_q, state_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire;
  logic             out_fire;

  assign in_fire   = in_valid & ready_q;
  assign out_fire  = valid_q & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // Ready is low here, so only the drain of M can happen.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    ready_d = (state_d != TWO);
    valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      main_q  <= main_d;
    end
  end

  always_ff @(posedge clock) begin
    skid_q <= skid_d;
  end

endmodule

// File: rtl/stream_differentiator.sv
// Inverse accumulator: emits truncated differences between consecutive accepted sums.
// Optional sticky range_error port enabled by STREAM_DIFFERENTIATOR_RANGE_CHECK_EN.
module stream_differentiator
  import stream_differentiator_pkg::*;
#(
  parameter int                  IN_WIDTH    = DEFAULT_IN_WIDTH,
  parameter int                  OUT_WIDTH   = DEFAULT_OUT_WIDTH,
  parameter logic [IN_WIDTH-1:0] INITIAL_SUM = '0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 input_valid,
  output logic                 input_ready,
  input  logic [IN_WIDTH-1:0]  input_data,
  output logic                 output_valid,
  input  logic                 output_ready,
  output logic [OUT_WIDTH-1:0] output_data,
  output logic [31:0]          accepted_count
`ifdef STREAM_DIFFERENTIATOR_RANGE_CHECK_EN
  ,
  output logic                 range_error
`endif
);

  logic                 input_fire;
  logic [OUT_WIDTH-1:0] diff_word;
  logic [IN_WIDTH-1:0]  prev_sum_q, prev_sum_d;
  logic [31:0]          count_q, count_d;

  assign input_fire = input_valid & input_ready;
  // Subtract at full input width first so wrap-around of the sums cancels out.
  assign diff_word  = OUT_WIDTH'(input_data - prev_sum_q);

  always_comb begin
    prev_sum_d = prev_sum_q;
    count_d    = count_q;
    if (input_fire) begin
      prev_sum_d = input_data;
      count_d    = count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_sum_q <= INITIAL_SUM;
      count_q    <= '0;
    end else begin
      prev_sum_q <= prev_sum_d;
      count_q    <= count_d;
    end
  end

  assign accepted_count = count_q;

  stream_differentiator_skid_buffer #(
    .WIDTH(OUT_WIDTH)
  ) u_skid (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (input_valid),
    .in_ready (input_ready),
    .in_data  (diff_word),
    .out_valid(output_valid),
    .out_ready(output_ready),
    .out_data (output_data)
  );

`ifdef STREAM_DIFFERENTIATOR_RANGE_CHECK_EN
  logic [IN_WIDTH-1:0] diff_full;
  logic                range_error_q, range_error_d;

  assign diff_full = input_data - prev_sum_q;

  always_comb begin
    range_error_d = range_error_q;
    if (input_fire && ((diff_full >> OUT_WIDTH) != '0)) begin
      range_error_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      range_error_q <= 1'b0;
    end else begin
      range_error_q <= range_error_d;
    end
  end

  assign range_error = range_error_q;
`endif

endmodule

// File: doc/stream_differentiator.md
Name: stream_differentiator

Overview:
- Valid/ready stream block that inverts the accumulator.
- Accepts a stream of IN_WIDTH-bit running sums and emits OUT_WIDTH-bit differences between consecutive accepted sums.
- Placed directly after an accumulator, it must reproduce that accumulator's input sequence exactly.
- Contains a 2-entry skid buffer so both handshake sides run at full throughput with registered ready.

Parameters:
- IN_WIDTH, 16, width of input sums.
- OUT_WIDTH, 8, width of output differences (must be <= IN_WIDTH).
- INITIAL_SUM, 0, value the "previous sum" register takes at reset; it is the reference for the first difference.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- input_valid  input  1  input word valid.
- input_ready  output  1  block can accept an input word (registered).
- input_data  input  IN_WIDTH  running sum.
- output_valid  output  1  output difference valid.
- output_ready  input  1  downstream accepts output.
- output_data  output  OUT_WIDTH  difference.
- accepted_count  output  32  number of input words accepted since reset, wraps modulo 2^32.

Behaviour:
- Reset (reset_n low, asynchronous assert, synchronous release):
  - input_ready=0, output_valid=0, output_data=0, accepted_count=0.
  - prev_sum=INITIAL_SUM; buffer state=EMPTY.
  - input_ready rises on the first clock edge after reset_n deasserts.
- Input handshake fires when input_valid && input_ready at a rising edge. On fire:
  - diff = (input_data - prev_sum) mod 2^IN_WIDTH; output word = diff[OUT_WIDTH-1:0].
  - prev_sum <= input_data; accepted_count increments.
- Output handshake fires when output_valid && output_ready.
- Output stays stable while output_valid=1 and output_ready=0 (AXI-style rules); input_valid never depends on input_ready.
- Latency: one cycle from input fire to output_valid=1 when the buffer is EMPTY.
- Buffer FSM: main register M drives the outputs; skid register S.
  - EMPTY: input_ready=1, output_valid=0. Input fire -> word to M, go to ONE.
  - ONE: input_ready=1, output_valid=1.
    - Input fire and output fire together -> new word to M, stay in ONE.
    - Input fire only -> word to S, go to TWO.
    - Output fire only -> go to EMPTY.
  - TWO: input_ready=0, output_valid=1. Output fire -> S moves to M, go to ONE.
- Maximum occupancy is 2. With output_ready held high the block sustains 1 word/cycle.
- Wrap-around: the subtraction is modular at IN_WIDTH and then truncated. Example: prev 0xFFFF, in 0x0002 -> diff 0x0003.
- Reset mid-operation discards any buffered words and restores prev_sum=INITIAL_SUM. No partial output is emitted.

Optional Feature:
- Macro: STREAM_DIFFERENTIATOR_RANGE_CHECK_EN.
- When defined, the block adds port range_error (output, 1):
  - Sticky flag, set on the cycle after an input fire whose full IN_WIDTH diff is >= 2^OUT_WIDTH.
  - Cleared only by reset; reset value 0.
  - Data path is unchanged; the truncated value is still emitted.
- When undefined, the port and its logic are absent.

Decomposition:
- Package stream_differentiator_pkg holds:
  - typedef enum logic [1:0] {EMPTY, ONE, TWO} for buffer state.
  - Default-width constants.
- One natural sub-module: skid_buffer, parameterised by WIDTH and implementing the FSM above. It is reused by other stream blocks. The differentiator top holds prev_sum, the subtractor, the counter and the optional range check.

Test Plan:
- Chain counter_8bit -> accumulator -> stream_differentiator; random output_ready at 80% duty; 1000 words -> outputs are exactly 0x00,0x01,...,0xFF,0x00,... in order; accepted_count=1000.
- Single input 0x0005 after reset, INITIAL_SUM=0 -> output_data=0x05 one cycle after fire; output_valid stays 1 until output_ready.
- Inputs 0xFFFF then 0x0002 (prev reset 0) -> outputs 0xFF then 0x03.
- output_ready=0 for 6 cycles with input_valid=1 constantly -> exactly 2 words accepted, input_ready=0 from the cycle after the second fire. After output_ready=1 both words drain in order and input_ready returns.
- Assert reset_n low mid-stream while in state TWO -> output_valid and input_ready drop immediately and asynchronously. After release, the first input 0x0010 yields 0x10.
- With STREAM_DIFFERENTIATOR_RANGE_CHECK_EN: inputs 0x0000 then 0x0100 -> output 0x00, range_error=1 and it stays 1 through subsequent in-range words until reset.
